fp_fx2f: RTL and testbench

FP_FX2F -- requirements
Module: fp_fx2f

---
 rtl/fp_fx2f.sv | 115 +++++++++++
 tb/tb_fp_fx2f.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_fx2f.sv
// rtl/fp_fx2f.sv - signed fixed-point to packed float converter, 3-stage pipeline
// Macro FP_FX2F_ROUND_EN selects round-to-nearest-even; the default build truncates.
module fp_fx2f #(
    parameter int EXP    = 5,
    parameter int MANT   = 10,
    parameter int WIDTH  = 1 + EXP + MANT,
    parameter int IWIDTH = 16,
    parameter int FRAC   = 0
) (
    input  logic              clock,
    input  logic              clock_sreset,
    input  logic              data_valid,
    input  logic [IWIDTH-1:0] dataa,
    output logic              result_valid,
    output logic [WIDTH-1:0]  result
);
    localparam int LZW   = $clog2(IWIDTH + 1);
    localparam int XW    = IWIDTH + MANT + 1;
    localparam int BIAS  = (1 << (EXP - 1)) - 1;
    localparam int EMAX  = (1 << EXP) - 1;
    localparam int EBASE = BIAS + IWIDTH - 1 - FRAC;

    // S1: sign and magnitude; IWIDTH unsigned bits hold |-2^(IWIDTH-1)| exactly
    logic              s1_valid;
    logic              s1_sign;
    logic [IWIDTH-1:0] s1_mag;

    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= data_valid;
        end
        if (data_valid) begin
            s1_sign <= dataa[IWIDTH-1];
            s1_mag  <= dataa[IWIDTH-1] ? (~dataa) + IWIDTH'(1) : dataa;
        end
    end

    // S2: leading-zero count, left-normalise, unbiased exponent
    logic [LZW-1:0] lz;

    always_comb begin
        lz = LZW'(IWIDTH);
        for (int i = 0; i < IWIDTH; i++) begin
            if (s1_mag[i]) begin
                lz = LZW'(IWIDTH - 1 - i);
            end
        end
    end

    logic               s2_valid;
    logic               s2_sign;
    logic               s2_zero;
    logic [IWIDTH-1:0]  s2_norm;
    logic signed [31:0] s2_exp;

    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
        end
        if (s1_valid) begin
            s2_sign <= s1_sign;
            s2_zero <= (s1_mag == '0);
            s2_norm <= s1_mag << lz;
            s2_exp  <= EBASE - int'(lz);
        end
    end

    // S3: round, exponent adjust, range clamp, pack
    logic [XW-1:0]      ext;
    logic [MANT-1:0]    mant_t;
    logic               round_up;
    logic [MANT:0]      mant_r;
    logic signed [31:0] exp_f;
    logic [WIDTH-1:0]   packed_c;
    logic               unused_bits;

    always_comb begin
        // hidden bit is dropped; zero padding covers IWIDTH-1 < MANT
        ext    = {s2_norm[IWIDTH-2:0], {(MANT + 2){1'b0}}};
        mant_t = ext[XW-1 -: MANT];
`ifdef FP_FX2F_ROUND_EN
        round_up = ext[XW-1-MANT] & ((|ext[XW-2-MANT:0]) | mant_t[0]);
`else
        round_up = 1'b0;
`endif
        mant_r = {1'b0, mant_t} + {{MANT{1'b0}}, round_up};
        exp_f  = mant_r[MANT] ? s2_exp + 32'sd1 : s2_exp;
        if (s2_zero || exp_f <= 32'sd0) begin
            packed_c = '0;
        end else if (exp_f >= EMAX) begin
            packed_c = {s2_sign, {EXP{1'b1}}, {MANT{1'b0}}};
        end else begin
            packed_c = {s2_sign, exp_f[EXP-1:0], mant_r[MANT-1:0]};
        end
    end

    assign unused_bits = ^{s2_norm[IWIDTH-1], ext[XW-1-MANT:0], exp_f[31:EXP]};

    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            result_valid <= 1'b0;
            result       <= '0;
        end else begin
            result_valid <= s2_valid;
            if (s2_valid) begin
                result <= packed_c;
            end
        end
    end

endmodule

// File: tb/tb_fp_fx2f.sv
// tb/tb_fp_fx2f.sv - self-checking bench for fp_fx2f (default, IWIDTH=20 and FRAC=20 instances)
module tb_fp_fx2f;
    logic        clock;
    logic        clock_sreset;
    logic        data_valid;
    logic [15:0] dataa;
    logic [19:0] dataa_w;
    logic        rv_m, rv_w, rv_f;
    logic [15:0] res_m, res_w, res_f;

    int vectors;
    int miscompares;

    // expected-output history: index 2 is what the outputs show now
    logic        pv[3];
    logic [15:0] pr_m[3], pr_w[3], pr_f[3];
    logic [15:0] er_m, er_w, er_f;

    logic [15:0] tbl32[8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                              16'h4500, 16'h4600, 16'h4700, 16'h4800};

    fp_fx2f dut (
        .clock(clock), .clock_sreset(clock_sreset), .data_valid(data_valid),
        .dataa(dataa), .result_valid(rv_m), .result(res_m)
    );

    fp_fx2f #(.IWIDTH(20)) dut_w (
        .clock(clock), .clock_sreset(clock_sreset), .data_valid(data_valid),
        .dataa(dataa_w), .result_valid(rv_w), .result(res_w)
    );

    fp_fx2f #(.FRAC(20)) dut_f (
        .clock(clock), .clock_sreset(clock_sreset), .data_valid(data_valid),
        .dataa(dataa), .result_valid(rv_f), .result(res_f)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // half-precision reference: find the leading power of two, scale, round on the remainder
    function automatic logic [15:0] fmodel(input longint v, input int frac);
        longint mag;
        longint q;
        int     e;
        int     ex;
        logic   s;
        s   = (v < 0);
        mag = s ? -v : v;
        if (mag == 0) return 16'h0000;
        e = 0;
        while ((mag >> (e + 1)) != 0) e++;
        if (e > 10) begin
            q = mag >> (e - 10);
`ifdef FP_FX2F_ROUND_EN
            begin
                longint rem;
                longint half;
                rem  = mag - (q << (e - 10));
                half = longint'(1) << (e - 11);
                if (rem > half || (rem == half && q[0])) q = q + 1;
            end
`endif
        end else begin
            q = mag << (10 - e);
        end
        if (q == 2048) begin
            q = 1024;
            e = e + 1;
        end
        ex = e + 15 - frac;
        if (ex >= 31) return {s, 5'h1F, 10'h000};
        if (ex <= 0) return 16'h0000;
        return {s, ex[4:0], q[9:0]};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_out(input string tag, input logic rv, input logic [15:0] res,
                              input logic [15:0] val);
        check({tag, "_valid"}, {15'b0, rv}, 16'h0001);
        check(tag, res, val);
    endtask

    task automatic step(input logic v, input logic signed [15:0] d, input logic signed [19:0] dw);
        data_valid = v;
        dataa      = d;
        dataa_w    = dw;
        @(posedge clock);
        #1;
        for (int i = 2; i > 0; i--) begin
            pv[i]   = pv[i-1];
            pr_m[i] = pr_m[i-1];
            pr_w[i] = pr_w[i-1];
            pr_f[i] = pr_f[i-1];
        end
        pv[0]   = v;
        pr_m[0] = fmodel(longint'(d), 0);
        pr_w[0] = fmodel(longint'(dw), 0);
        pr_f[0] = fmodel(longint'(d), 20);
        if (pv[2]) begin
            er_m = pr_m[2];
            er_w = pr_w[2];
            er_f = pr_f[2];
        end
        check("model_valid_m", {15'b0, rv_m}, {15'b0, pv[2]});
        check("model_result_m", res_m, er_m);
        check("model_valid_w", {15'b0, rv_w}, {15'b0, pv[2]});
        check("model_result_w", res_w, er_w);
        check("model_valid_f", {15'b0, rv_f}, {15'b0, pv[2]});
        check("model_result_f", res_f, er_f);
    endtask

    task automatic rst_step(input logic v);
        clock_sreset = 1'b1;
        data_valid   = v;
        dataa        = 16'd77;
        dataa_w      = 20'd77;
        @(posedge clock);
        #1;
        clock_sreset = 1'b0;
        data_valid   = 1'b0;
        for (int i = 0; i < 3; i++) pv[i] = 1'b0;
        er_m = 16'h0;
        er_w = 16'h0;
        er_f = 16'h0;
        check("rst_valid_m", {15'b0, rv_m}, 16'h0000);
        check("rst_result_m", res_m, 16'h0000);
        check("rst_valid_w", {15'b0, rv_w}, 16'h0000);
        check("rst_result_w", res_w, 16'h0000);
        check("rst_valid_f", {15'b0, rv_f}, 16'h0000);
        check("rst_result_f", res_f, 16'h0000);
    endtask

    initial begin
        logic signed [15:0] rd;
        logic signed [19:0] rw;
        vectors      = 0;
        miscompares  = 0;
        clock_sreset = 1'b1;
        data_valid   = 1'b0;
        dataa        = '0;
        dataa_w      = '0;
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0; pr_m[i] = '0; pr_w[i] = '0; pr_f[i] = '0;
        end
        er_m = '0; er_w = '0; er_f = '0;
        @(posedge clock);
        #1;
        rst_step(1'b1);

        // alternate-cycle pulses with exact latency
        step(1'b1, 16'sd123, 20'sd0);
        step(1'b0, 16'sd0, 20'sd0);
        step(1'b1, 16'sd130, 20'sd0);
        expect_out("alt_123", rv_m, res_m, 16'h57B0);
        step(1'b0, 16'sd0, 20'sd0);
        step(1'b1, 16'sd137, 20'sd0);
        expect_out("alt_130", rv_m, res_m, 16'h5810);
        step(1'b0, 16'sd0, 20'sd0);
        step(1'b0, 16'sd0, 20'sd0);
        expect_out("alt_137", rv_m, res_m, 16'h5848);
        step(1'b0, 16'sd0, 20'sd0);

        // rounding, carry, sign, zero, most-negative, overflow to infinity
        step(1'b1, 16'sd2051, 20'sh20000);
        step(1'b1, 16'sd2049, -20'sh20000);
        step(1'b1, 16'sd4095, 20'sd0);
`ifdef FP_FX2F_ROUND_EN
        expect_out("round_2051", rv_m, res_m, 16'h6802);
`else
        expect_out("trunc_2051", rv_m, res_m, 16'h6801);
`endif
        expect_out("w20_pos_inf", rv_w, res_w, 16'h7C00);
        step(1'b1, -16'sd1, 20'sd0);
        expect_out("tie_2049", rv_m, res_m, 16'h6800);
        expect_out("w20_neg_inf", rv_w, res_w, 16'hFC00);
        step(1'b1, 16'sd0, 20'sd0);
`ifdef FP_FX2F_ROUND_EN
        expect_out("carry_4095", rv_m, res_m, 16'h6C00);
`else
        expect_out("trunc_4095", rv_m, res_m, 16'h6BFF);
`endif
        step(1'b1, -16'sd32768, 20'sd0);
        expect_out("minus_one", rv_m, res_m, 16'hBC00);
        step(1'b0, 16'sd0, 20'sd0);
        expect_out("zero", rv_m, res_m, 16'h0000);
        step(1'b0, 16'sd0, 20'sd0);
        expect_out("most_negative", rv_m, res_m, 16'hF800);
        step(1'b0, 16'sd0, 20'sd0);

        // back-to-back throughput, FRAC=20 underflow on dataa=1
        for (int k = 0; k < 10; k++) begin
            step(k < 8, 16'(k + 1), 20'sd0);
            if (k >= 2) expect_out("burst", rv_m, res_m, tbl32[k-2]);
            if (k == 2) expect_out("frac20_flush", rv_f, res_f, 16'h0000);
        end
        step(1'b0, 16'sd0, 20'sd0);

        // reset with two conversions in flight
        step(1'b1, 16'sd100, 20'sd0);
        step(1'b1, 16'sd200, 20'sd0);
        rst_step(1'b1);
        step(1'b0, 16'sd0, 20'sd0);
        check("flush_valid_1", {15'b0, rv_m}, 16'h0000);
        check("flush_result_1", res_m, 16'h0000);
        step(1'b0, 16'sd0, 20'sd0);
        check("flush_valid_2", {15'b0, rv_m}, 16'h0000);
        step(1'b1, 16'sd5, 20'sd0);
        check("post_rst_lat_1", {15'b0, rv_m}, 16'h0000);
        step(1'b0, 16'sd0, 20'sd0);
        check("post_rst_lat_2", {15'b0, rv_m}, 16'h0000);
        step(1'b0, 16'sd0, 20'sd0);
        expect_out("post_rst_5", rv_m, res_m, 16'h4500);

        // randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            rd = 16'($urandom);
            rw = 20'($urandom);
            rd = rd >>> $urandom_range(0, 15);
            rw = rw >>> $urandom_range(0, 19);
            if ($urandom_range(0, 49) == 0) rst_step(1'($urandom_range(0, 1)));
            else step(1'($urandom_range(0, 1)), rd, rw);
        end
        for (int n = 0; n < 3; n++) step(1'b0, 16'sd0, 20'sd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
